jk_count_controller: RTL and testbench
======================================

JK_COUNT_CONTROLLER -- requirements
Module: jk_count_controller

Interface
REQ-001 Parameter WIDTH, default 4, number of JK flip-flop bits sequenced by the controller.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 start  input  1  level; request to enter or resume counting.
REQ-005 stop  input  1  level; request to pause, or to finish from pause.
REQ-006 up_dn  input  1  count direction: 1 = up, 0 = down; sampled every RUN cycle.
REQ-007 oneshot  input  1  1 = stop automatically after one terminal count; sampled every RUN cycle.
REQ-008 modulus  input  WIDTH  count range 0..modulus-1; modulus 0 means 2^WIDTH.
REQ-009 load  input  1  parallel-load request.
REQ-010 load_val  input  WIDTH  value loaded when load is accepted.
REQ-011 q  output  WIDTH  count value, taken directly from the JK cell outputs.
REQ-012 busy  output  1  1 in RUN or HOLD.
REQ-013 tc  output  1  terminal-count decode: RUN and q equals the terminal value.
REQ-014 done  output  1  one-cycle pulse on return to IDLE from RUN or HOLD.

Function
REQ-015 FSM states SHALL be IDLE, RUN and HOLD; busy SHALL be combinational from the state.
REQ-016 Terminal value SHALL be modulus-1 when up_dn=1, and 0 when up_dn=0.
REQ-017 IDLE: start=1 -> RUN next cycle, with q unchanged on that edge; load=1 (start=0, stop=0) -> q <= load_val next cycle.
REQ-018 IDLE: start=1 together with load=1 SHALL load on the same edge as the RUN transition.
REQ-019 RUN, stop=0: q SHALL step by 1 per cycle in the selected direction, with one-cycle latency.
REQ-020 Up wrap: q >= modulus-1 -> q <= 0.
REQ-021 Down wrap: q == 0 -> q <= modulus-1.
REQ-022 Down, out of range: q > modulus-1 -> q <= q-1.
REQ-023 RUN: stop=1 -> HOLD; q SHALL freeze on that edge.
REQ-024 RUN: stop has priority over start; load is ignored.
REQ-025 RUN with oneshot=1 and tc=1: the next edge SHALL apply the wrap, go to IDLE and pulse done=1 for one cycle.
REQ-026 HOLD: start=1 and stop=0 -> RUN.
REQ-027 HOLD: stop=1 -> IDLE with done=1 for one cycle.
REQ-028 HOLD: load=1 (start=0, stop=0) -> q <= load_val, state unchanged.
REQ-029 HOLD: q otherwise frozen.
REQ-030 Per-bit JK command, count: toggle (j=k=1) for bits in q XOR next_q, hold (j=k=0) for all other bits.
REQ-031 Per-bit JK command, load: j=load_val[i], k=~load_val[i].
REQ-032 Per-bit JK command, reset: j=0, k=1.
REQ-033 All arithmetic SHALL be WIDTH bits modulo 2^WIDTH; modulus-1 with modulus=0 SHALL evaluate to all-ones.

Reset
REQ-034 rst=0 at a rising edge SHALL force q=0, state IDLE, busy=0, tc=0 and done=0 on that edge, regardless of any other input.
REQ-035 Reset asserted mid-RUN or mid-HOLD SHALL abort the count with no done pulse.
REQ-036 Outputs SHALL hold their reset values while rst=0.
REQ-037 There SHALL be no asynchronous path from rst to any flop.

Structure
REQ-038 Shared package jk_ctrl_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, HOLD=2'b10) and the JK command constants (HOLD=00, RESET=01, SET=10, TOGGLE=11).
REQ-039 Sub-module jk_cell SHALL be one rising-edge JK bit (00 hold, 01 clear, 10 set, 11 toggle) with synchronous active-low rst, instantiated WIDTH times.
REQ-040 The FSM and JK command generation SHALL reside in jk_count_controller.

Verification
REQ-041 rst=0 for 2 cycles with start=1, load=1, load_val=4'hA -> q=0, busy=0, done=0 throughout.
REQ-042 modulus=5, up_dn=1, start held 8 cycles -> q 0,1,2,3,4,0,1,2; tc=1 exactly while q=4.
REQ-043 modulus=0, up_dn=0, load_val=1, load then start -> q 1,0,F,E; the 0->F wrap occurs.
REQ-044 modulus=6, oneshot=1, up, start 1 cycle from q=0 -> q reaches 5, then 0; state IDLE; done=1 for one cycle; busy=0.
REQ-045 RUN at q=3: stop 1 cycle -> q frozen at 3 in HOLD; load_val=9 with load -> q=9; start -> counting resumes from 9; stop twice -> IDLE with done pulse.
REQ-046 rst=0 asserted while RUN at q=7 -> q=0 and IDLE next edge, no done; start=1 with stop=1 in RUN -> HOLD.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK-flip-flop count controller.
//   state_e  : controller FSM encoding (IDLE / RUN / HOLD)
//   jk_cmd_t : per-bit {j, k} command driven into each jk_cell
package jk_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHold = 2'b10
  } state_e;

  typedef logic [1:0] jk_cmd_t;

  // {j, k} encodings
  localparam jk_cmd_t JkHold   = 2'b00;
  localparam jk_cmd_t JkReset  = 2'b01;
  localparam jk_cmd_t JkSet    = 2'b10;
  localparam jk_cmd_t JkToggle = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single rising-edge JK flip-flop bit with synchronous active-low reset.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active low (clears the bit)
//   i_j  : J input
//   i_k  : K input
//   o_q  : stored bit
// {j,k}: 00 hold, 01 clear, 10 set, 11 toggle.
module jk_cell
  import jk_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= 1'b0;
    end else begin
      case ({i_j, i_k})
        JkHold:   r_q <= r_q;
        JkReset:  r_q <= 1'b0;
        JkSet:    r_q <= 1'b1;
        JkToggle: r_q <= ~r_q;
        default:  r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/jk_count_controller.sv
// Modulo up/down counter built from WIDTH JK flip-flops, sequenced by a
// small IDLE/RUN/HOLD controller that turns count/load/reset intents into
// per-bit {j,k} commands.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous reset, active low
//   start     : level, enter or resume counting
//   stop      : level, pause from RUN, finish from HOLD
//   up_dn     : direction, 1 = up, 0 = down
//   oneshot   : return to IDLE after one terminal count
//   modulus   : count range 0..modulus-1 (0 means 2^WIDTH)
//   load      : parallel-load request (IDLE or HOLD)
//   load_val  : value to load
//   q         : count value straight from the JK cells
//   busy      : in RUN or HOLD
//   tc        : RUN and q at the terminal value for the current direction
//   done      : one-cycle pulse after returning to IDLE from RUN/HOLD
module jk_count_controller
  import jk_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] modulus,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_done;
  logic             w_done_next;
  logic             w_do_count;
  logic             w_do_load;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_mod_m1;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  jk_cmd_t          w_cmd;

  // modulus 0 wraps to all-ones, giving the full 2^WIDTH range.
  assign w_mod_m1 = modulus - WIDTH'(1);
  assign w_term   = up_dn ? w_mod_m1 : '0;

  // Next count value. Up uses >= so an out-of-range value wraps straight to 0;
  // down from an out-of-range value simply decrements toward the range.
  always_comb begin
    w_count_next = w_q;
    if (up_dn) begin
      w_count_next = (w_q >= w_mod_m1) ? '0 : w_q + WIDTH'(1);
    end else begin
      w_count_next = (w_q == '0) ? w_mod_m1 : w_q - WIDTH'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state and datapath intent
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    w_do_count   = 1'b0;
    w_do_load    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = StRun;
          w_do_load    = load;
        end else if (load && !stop) begin
          w_do_load = 1'b1;
        end
      end
      StRun: begin
        // stop wins over start; load is ignored while running.
        if (stop) begin
          w_state_next = StHold;
        end else begin
          w_do_count = 1'b1;
          if (oneshot && tc) begin
            w_state_next = StIdle;
            w_done_next  = 1'b1;
          end
        end
      end
      StHold: begin
        if (stop) begin
          w_state_next = StIdle;
          w_done_next  = 1'b1;
        end else if (start) begin
          w_state_next = StRun;
        end else if (load) begin
          w_do_load = 1'b1;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Outputs and per-bit JK commands
  always_comb begin
    busy  = (r_state == StRun) || (r_state == StHold);
    tc    = (r_state == StRun) && (w_q == w_term);
    w_cmd = JkHold;
    w_j   = '0;
    w_k   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_cmd = JkHold;
      if (!rst) begin
        w_cmd = JkReset;
      end else if (w_do_load) begin
        w_cmd = {load_val[i], ~load_val[i]};
      end else if (w_do_count && (w_q[i] ^ w_count_next[i])) begin
        w_cmd = JkToggle;
      end
      w_j[i] = w_cmd[1];
      w_k[i] = w_cmd[0];
    end
  end

  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .i_j (w_j[gi]),
      .i_k (w_k[gi]),
      .o_q (w_q[gi])
    );
  end

  assign q    = w_q;
  assign done = r_done;

endmodule

// File: tb/tb_jk_count_controller.sv
// Directed bench for jk_count_controller (WIDTH = 4). Each vector holds one
// cycle of inputs and the outputs expected just after the following edge.
module tb_jk_count_controller;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         up_dn = 1'b1;
  logic         oneshot = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] modulus = '0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic         busy;
  logic         tc;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst, start, stop, up, os, ld;
    logic [3:0] mod, lv, eq;
    logic       eb, et, ed;
  } vec_t;

  vec_t vecs[$];

  jk_count_controller #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .up_dn    (up_dn),
    .oneshot  (oneshot),
    .modulus  (modulus),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .busy     (busy),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic row(input logic r, s, p, u, o, l, input logic [3:0] m, v, eq,
                     input logic eb, et, ed);
    vec_t x;
    x.rst = r; x.start = s; x.stop = p; x.up = u; x.os = o; x.ld = l;
    x.mod = m; x.lv = v; x.eq = eq; x.eb = eb; x.et = et; x.ed = ed;
    vecs.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eq,
                       input logic eb, et, ed);
    n_tests++;
    if (q !== eq || busy !== eb || tc !== et || done !== ed) begin
      n_fail++;
      $display("FAIL %s: got q=%h busy=%b tc=%b done=%b, want q=%h busy=%b tc=%b done=%b",
               name, q, busy, tc, done, eq, eb, et, ed);
    end
  endtask

  initial begin
    // Reset held with start/load active: nothing may move.
    row(0,1,0,1,0,1, 4'd5, 4'hA, 4'h0, 0,0,0);
    row(0,1,0,1,0,1, 4'd5, 4'hA, 4'h0, 0,0,0);
    // modulus 5, up, start held 8 cycles.
    row(1,1,0,1,0,0, 4'd5, 4'h0, 4'h0, 1,0,0);
    row(1,1,0,1,0,0, 4'd5, 4'h0, 4'h1, 1,0,0);
    row(1,1,0,1,0,0, 4'd5, 4'h0, 4'h2, 1,0,0);
    row(1,1,0,1,0,0, 4'd5, 4'h0, 4'h3, 1,0,0);
    row(1,1,0,1,0,0, 4'd5, 4'h0, 4'h4, 1,1,0);
    row(1,1,0,1,0,0, 4'd5, 4'h0, 4'h0, 1,0,0);
    row(1,1,0,1,0,0, 4'd5, 4'h0, 4'h1, 1,0,0);
    row(1,1,0,1,0,0, 4'd5, 4'h0, 4'h2, 1,0,0);
    // stop -> HOLD, stop -> IDLE with done.
    row(1,0,1,1,0,0, 4'd5, 4'h0, 4'h2, 1,0,0);
    row(1,0,1,1,0,0, 4'd5, 4'h0, 4'h2, 0,0,1);
    row(1,0,0,1,0,0, 4'd5, 4'h0, 4'h2, 0,0,0);
    // modulus 0, down: load 1 then count 1,0,F,E.
    row(1,0,0,0,0,1, 4'd0, 4'h1, 4'h1, 0,0,0);
    row(1,1,0,0,0,0, 4'd0, 4'h0, 4'h1, 1,0,0);
    row(1,1,0,0,0,0, 4'd0, 4'h0, 4'h0, 1,1,0);
    row(1,1,0,0,0,0, 4'd0, 4'h0, 4'hF, 1,0,0);
    row(1,1,0,0,0,0, 4'd0, 4'h0, 4'hE, 1,0,0);
    row(1,0,1,0,0,0, 4'd0, 4'h0, 4'hE, 1,0,0);
    row(1,0,1,0,0,0, 4'd0, 4'h0, 4'hE, 0,0,1);
    // start+load in IDLE: load on the RUN transition edge.
    row(1,1,0,1,0,1, 4'd0, 4'h3, 4'h3, 1,0,0);
    // RUN at 3: stop -> HOLD frozen, load 9, resume, stop twice.
    row(1,0,1,1,0,0, 4'd0, 4'h0, 4'h3, 1,0,0);
    row(1,0,0,1,0,1, 4'd0, 4'h9, 4'h9, 1,0,0);
    row(1,1,0,1,0,0, 4'd0, 4'h0, 4'h9, 1,0,0);
    row(1,0,0,1,0,0, 4'd0, 4'h0, 4'hA, 1,0,0);
    row(1,0,1,1,0,0, 4'd0, 4'h0, 4'hA, 1,0,0);
    row(1,0,1,1,0,0, 4'd0, 4'h0, 4'hA, 0,0,1);
    row(1,0,0,1,0,0, 4'd0, 4'h0, 4'hA, 0,0,0);
    // Reset mid-RUN at q=7: no done afterwards.
    row(1,0,0,1,0,1, 4'd0, 4'h7, 4'h7, 0,0,0);
    row(1,1,0,1,0,0, 4'd0, 4'h0, 4'h7, 1,0,0);
    row(0,1,0,1,0,0, 4'd0, 4'h0, 4'h0, 0,0,0);
    row(1,0,0,1,0,0, 4'd0, 4'h0, 4'h0, 0,0,0);
    // start and stop together in RUN -> HOLD.
    row(1,1,0,1,0,0, 4'd0, 4'h0, 4'h0, 1,0,0);
    row(1,1,1,1,0,0, 4'd0, 4'h0, 4'h0, 1,0,0);
    row(1,0,1,1,0,0, 4'd0, 4'h0, 4'h0, 0,0,1);
    // Out-of-range values with modulus 5: down decrements, up wraps to 0.
    row(1,0,0,0,0,1, 4'd5, 4'h9, 4'h9, 0,0,0);
    row(1,1,0,0,0,0, 4'd5, 4'h0, 4'h9, 1,0,0);
    row(1,0,0,0,0,0, 4'd5, 4'h0, 4'h8, 1,0,0);
    row(1,0,1,0,0,0, 4'd5, 4'h0, 4'h8, 1,0,0);
    row(1,0,1,0,0,0, 4'd5, 4'h0, 4'h8, 0,0,1);
    row(1,1,0,1,0,0, 4'd5, 4'h0, 4'h8, 1,0,0);
    row(1,0,0,1,0,0, 4'd5, 4'h0, 4'h0, 1,0,0);
    row(0,0,0,1,0,0, 4'd5, 4'h0, 4'h0, 0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst      = vecs[i].rst;
      start    = vecs[i].start;
      stop     = vecs[i].stop;
      up_dn    = vecs[i].up;
      oneshot  = vecs[i].os;
      load     = vecs[i].ld;
      modulus  = vecs[i].mod;
      load_val = vecs[i].lv;
      tick();
      check($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eb, vecs[i].et, vecs[i].ed);
    end

    // Oneshot, modulus 6, up: one-cycle start from q=0, runs to 5, wraps, ends.
    rst = 1'b1; start = 1'b1; stop = 1'b0; up_dn = 1'b1; oneshot = 1'b1;
    load = 1'b0; modulus = 4'd6; load_val = 4'h0;
    tick();
    check("oneshot_start", 4'h0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("oneshot_q%0d", k), 4'(k), 1'b1, (k == 5), 1'b0);
    end
    tick();
    check("oneshot_end", 4'h0, 1'b0, 1'b0, 1'b1);
    tick();
    check("oneshot_done_clear", 4'h0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
